// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: default widths, BTB entry layout and 2-bit
// direction counter encodings with their saturating update helper.
package if_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

  // Widest PC the entry layout can carry; narrower fields are zero-extended.
  localparam int XLEN_MAX = 64;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [XLEN_MAX-1:0] tag;
    logic [1:0]          ctr;
    logic [XLEN_MAX-1:0] target;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// One combinational lookup port and one registered update port.
module pc_btb
  import if_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:2] lk_pc,
  output logic            lk_taken,
  output logic [XLEN-1:0] lk_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:2] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_mem [BTB_ENTRIES];
  logic [1:0]             ctr_mem [BTB_ENTRIES];
  logic [XLEN-1:0]        tgt_mem [BTB_ENTRIES];

  logic [IDX-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t lk_e, up_e, up_n;
  logic up_hit, upd_we;
  logic unused_bits;

  assign lk_idx = lk_pc[IDX+1:2];
  assign lk_tag = lk_pc[XLEN-1:IDX+2];
  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX+2];

  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no path leaves a variable unassigned (no latch).
  always_comb begin
    lk_e = '{valid:  valid_q[lk_idx],
             tag:    XLEN_MAX'(tag_mem[lk_idx]),
             ctr:    ctr_mem[lk_idx],
             target: XLEN_MAX'(tgt_mem[lk_idx])};
    lk_taken  = lk_e.valid && (lk_e.tag == XLEN_MAX'(lk_tag)) && lk_e.ctr[1];
    lk_target = lk_e.target[XLEN-1:0];
  end

  always_comb begin
    up_e = '{valid:  valid_q[up_idx],
             tag:    XLEN_MAX'(tag_mem[up_idx]),
             ctr:    ctr_mem[up_idx],
             target: XLEN_MAX'(tgt_mem[up_idx])};
    up_hit = up_e.valid && (up_e.tag == XLEN_MAX'(up_tag));
    up_n   = up_e;
    upd_we = 1'b0;
    if (upd_valid && rst) begin
      if (up_hit) begin
        upd_we     = 1'b1;
        up_n.ctr   = ctr_next(up_e.ctr, upd_taken);
        if (upd_taken) up_n.target = XLEN_MAX'(upd_target);
      end else if (upd_taken) begin
        upd_we = 1'b1;
        up_n   = '{valid: 1'b1, tag: XLEN_MAX'(up_tag), ctr: WT,
                   target: XLEN_MAX'(upd_target)};
      end
    end
  end

  // NOTE: sequential state is written with non-blocking '<=' so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst)        valid_q         <= '0;
    else if (upd_we) valid_q[up_idx] <= 1'b1;
  end

  // NOTE: the table payload is deliberately not reset; valid_q alone
  // qualifies it, which keeps the arrays as plain RAM-style storage.
  always_ff @(posedge clk) begin
    if (upd_we) begin
      tag_mem[up_idx] <= up_n.tag[TAG_W-1:0];
      ctr_mem[up_idx] <= up_n.ctr;
      tgt_mem[up_idx] <= up_n.target[XLEN-1:0];
    end
  end

  assign unused_bits = ^{lk_e, up_n};

endmodule

// File: rtl/pc_gen_bp.sv
// Fetch-stage PC generator with optional BTB-based branch prediction.
// Define PC_GEN_BTB_EN to build the BTB and predictor; otherwise fetch is sequential.
module pc_gen_bp
  import if_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int              BTB_ENTRIES  = 16,
  parameter int              STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               upd_valid,
  input  logic [XLEN-1:0]    upd_pc,
  input  logic [XLEN-1:0]    upd_target,
  input  logic               upd_taken,
  output logic               ce,
  output logic [XLEN-1:0]    pc,
  output logic               pred_taken,
  output logic [XLEN-1:0]    pred_target
);

  logic [XLEN-1:0] pc_seq, pc_next;
  logic unused_in;

  assign pc_seq = pc + XLEN'(4);

`ifdef PC_GEN_BTB_EN
  logic            btb_taken;
  logic [XLEN-1:0] btb_target;

  pc_btb #(.XLEN(XLEN), .BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lk_pc      (pc[XLEN-1:2]),
    .lk_taken   (btb_taken),
    .lk_target  (btb_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc[XLEN-1:2]),
    .upd_target (upd_target),
    .upd_taken  (upd_taken)
  );

  assign pred_taken  = btb_taken;
  assign pred_target = btb_taken ? btb_target : pc_seq;
  assign unused_in   = ^{stall, redirect_pc[1:0], upd_pc[1:0]};
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_seq;
  assign unused_in   = ^{stall, redirect_pc[1:0], upd_valid, upd_pc, upd_target, upd_taken};
`endif

  always_comb begin
    pc_next = pc_seq;
    if (redirect)        pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    else if (stall[0])   pc_next = pc;
    else if (pred_taken) pc_next = pred_target;
  end

  // ce comes up one edge after reset releases; pc sits on the vector until then.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ce <= 1'b0;
      pc <= RESET_VECTOR;
    end else if (!ce) begin
      ce <= 1'b1;
      pc <= RESET_VECTOR;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_gen_bp.sv
// Directed bench for pc_gen_bp; expectations adapt to whether PC_GEN_BTB_EN is defined.
module tb_pc_gen_bp;

`ifdef PC_GEN_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc, upd_target;
  logic        upd_taken;
  logic        ce;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_gen_bp dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .ce          (ce),
    .pc          (pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall0;
    logic        redir;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        ut;
    logic [31:0] pc_bp;   // expected pc with the predictor built in
    logic [31:0] pc_nb;   // expected pc without it
    logic        pt;      // expected pred_taken with the predictor
    logic [31:0] tgt;     // expected pred_target with the predictor
  } vec_t;

  vec_t v[21];

  function automatic vec_t mk(logic s, logic r, logic [31:0] rp, logic u, logic [31:0] up,
                              logic [31:0] ug, logic t, logic [31:0] eb, logic [31:0] en,
                              logic ep, logic [31:0] et);
    vec_t x;
    x = '{s, r, rp, u, up, ug, t, eb, en, ep, et};
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic u,
                       input logic [31:0] up, input logic [31:0] ug, input logic t);
    stall       = {5'b0, s};
    redirect    = r;
    redirect_pc = rp;
    upd_valid   = u;
    upd_pc      = up;
    upd_target  = ug;
    upd_taken   = t;
  endtask

  task automatic check_pred(input string name, input logic [31:0] exp_pc,
                            input logic exp_pt_bp, input logic [31:0] exp_tgt_bp);
    check({name, ".pc"}, pc, exp_pc);
    check({name, ".pred_taken"}, {31'b0, pred_taken}, {31'b0, BTB ? exp_pt_bp : 1'b0});
    check({name, ".pred_target"}, pred_target, BTB ? exp_tgt_bp : exp_pc + 32'd4);
  endtask

  initial begin
    //            stall redir rpc           uv upc     utgt    ut  pc_bp         pc_nb         pt tgt
    v[0]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h10,       32'h10,       0, 32'h14);
    v[1]  = mk(1, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h10,       32'h10,       0, 32'h14);
    v[2]  = mk(1, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h10,       32'h10,       0, 32'h14);
    v[3]  = mk(1, 1, 32'h203,      0, 32'h0,  32'h0,   0, 32'h200,      32'h200,      0, 32'h204);
    v[4]  = mk(0, 1, 32'h40,       1, 32'h40, 32'h100, 1, 32'h40,       32'h40,       1, 32'h100);
    v[5]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h100,      32'h44,       0, 32'h104);
    v[6]  = mk(0, 1, 32'h40,       1, 32'h40, 32'h100, 0, 32'h40,       32'h40,       0, 32'h44);
    v[7]  = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h44,       32'h44,       0, 32'h48);
    v[8]  = mk(1, 0, 32'h0,        1, 32'h40, 32'h100, 1, 32'h44,       32'h44,       0, 32'h48);
    v[9]  = mk(1, 0, 32'h0,        1, 32'h40, 32'h100, 1, 32'h44,       32'h44,       0, 32'h48);
    v[10] = mk(0, 1, 32'h40,       1, 32'h40, 32'h100, 0, 32'h40,       32'h40,       1, 32'h100);
    v[11] = mk(0, 1, 32'h80,       0, 32'h0,  32'h0,   0, 32'h80,       32'h80,       0, 32'h84);
    v[12] = mk(0, 1, 32'hFFFFFFFC, 0, 32'h0,  32'h0,   0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 32'h0);
    v[13] = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h0,        32'h0,        0, 32'h4);
    v[14] = mk(0, 1, 32'h40,       0, 32'h0,  32'h0,   0, 32'h40,       32'h40,       1, 32'h100);
    v[15] = mk(0, 0, 32'h0,        1, 32'h40, 32'h100, 0, 32'h100,      32'h44,       0, 32'h104);
    v[16] = mk(0, 1, 32'h40,       0, 32'h0,  32'h0,   0, 32'h40,       32'h40,       0, 32'h44);
    v[17] = mk(0, 1, 32'h60,       0, 32'h0,  32'h0,   0, 32'h60,       32'h60,       0, 32'h64);
    v[18] = mk(1, 0, 32'h0,        1, 32'h60, 32'h300, 1, 32'h60,       32'h60,       1, 32'h300);
    v[19] = mk(0, 0, 32'h0,        0, 32'h0,  32'h0,   0, 32'h300,      32'h64,       0, 32'h304);
    v[20] = mk(0, 1, 32'h60,       1, 32'hA0, 32'h500, 0, 32'h60,       32'h60,       1, 32'h300);

    // Reset held for three edges, then fetch starts from the vector.
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset%0d.ce", i), {31'b0, ce}, 32'h0);
      check($sformatf("reset%0d.pc", i), pc, 32'h0);
    end
    rst = 1'b1;
    step();
    check("first.ce", {31'b0, ce}, 32'h1);
    check_pred("first", 32'h0, 1'b0, 32'h4);
    step();
    check("seq4", pc, 32'h4);
    step();
    check("seq8", pc, 32'h8);
    step();
    check("seqC", pc, 32'hC);

    for (int i = 0; i < 21; i++) begin
      drive(v[i].stall0, v[i].redir, v[i].rpc, v[i].uv, v[i].upc, v[i].utgt, v[i].ut);
      step();
      check_pred($sformatf("vec%0d", i), BTB ? v[i].pc_bp : v[i].pc_nb, v[i].pt, v[i].tgt);
    end

    // Mid-run reset: valid bits cleared and the concurrent update dropped.
    rst = 1'b0;
    drive(0, 0, 32'h0, 1, 32'h20, 32'h400, 1);
    step();
    check("midrst.ce", {31'b0, ce}, 32'h0);
    check("midrst.pc", pc, 32'h0);
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    step();
    check("midrst.ce_up", {31'b0, ce}, 32'h1);
    drive(0, 1, 32'h60, 0, 32'h0, 32'h0, 0);
    step();
    check_pred("postrst60", 32'h60, 1'b0, 32'h64);
    drive(0, 1, 32'h20, 0, 32'h0, 32'h0, 0);
    step();
    check_pred("postrst20", 32'h20, 1'b0, 32'h24);
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    step();
    check("postrst24", pc, 32'h24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen_bp.md
# pc_gen_bp

Parametrised program-counter generator for the fetch stage, with a built-in direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It drives the instruction-memory address and chip enable, and attaches a taken/target prediction to every fetched PC for decode to carry down the pipeline. Resolved redirects from execute override both sequential fetch and prediction.

## Interface
Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 0, first fetch address; bits [1:0] must be 0.
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥2. IDX = log2(BTB_ENTRIES).
- STALL_W, 6, width of the pipeline stall vector.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- stall  in  STALL_W  pipeline stall vector; bit 0 holds the PC.
- redirect  in  1  resolved branch/jump or mispredict from execute.
- redirect_pc  in  XLEN  correct next PC; bits [1:0] are ignored and treated as 0.
- upd_valid  in  1  execute resolved a control-flow instruction this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_target  in  XLEN  its computed target.
- upd_taken  in  1  its actual direction.
- ce  out  1  instruction-memory enable.
- pc  out  XLEN  current fetch address.
- pred_taken  out  1  prediction for the current pc.
- pred_target  out  XLEN  predicted next PC for the current pc; pc+4 when not taken.

## Operation
- Reset (rst=0 at an edge): ce←0, pc←RESET_VECTOR, all BTB valid bits←0. Counters, tags and targets are not reset.
- ce←1 on the first edge with rst=1. While ce=0, pc holds RESET_VECTOR.
- Next-PC priority when ce=1 (highest first):
  - redirect → {redirect_pc[XLEN-1:2],2'b00}. Redirect overrides stall[0].
  - stall[0] → hold pc.
  - pred_taken → pred_target.
  - otherwise pc+4, modulo 2^XLEN (0xFFFFFFFC → 0x00000000 at XLEN=32).
- BTB lookup is on the current pc:
  - index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
  - Hit = valid && tag match.
  - pred_taken = hit && ctr[1].
- BTB update is on upd_valid, using upd_pc's index/tag:
  - Miss and upd_taken: allocate with valid=1, tag, target=upd_target, ctr=2'b10 (weakly taken).
  - Miss and not taken: no change.
  - Hit: ctr saturating +1 if taken, −1 if not (bounds 00/11). Target overwritten when taken.
- upd_valid is honoured regardless of stall and redirect. An update during reset is dropped.

## Timing
- pc is registered. pred_taken and pred_target are combinational from pc and BTB state within the same cycle.
- Lookup and update on the same index in the same cycle: the lookup sees the old entry; the new entry is visible from the next cycle.
- Redirect latency is 1 cycle: redirect asserted in cycle n gives pc=redirect_pc in cycle n+1.
- Reset mid-operation takes effect at the next edge. ce falls in the same edge; the pipeline must treat ce=0 as a bubble.

## Configuration
- PC_GEN_BTB_EN defined: BTB and predictor are present as described.
- PC_GEN_BTB_EN undefined:
  - No BTB storage.
  - pred_taken=0; pred_target=pc+4.
  - upd_* inputs are ignored.
  - Next-PC priority is redirect > stall > pc+4.

## Structure
- Shared package if_pkg holds:
  - Default XLEN and RESET_VECTOR.
  - The btb_entry_t struct (valid, tag, ctr[1:0], target).
  - Counter constants: SNT=00, WNT=01, WT=10, ST=11.
- Sub-module pc_btb contains the table, the lookup port and the update port. It is instantiated only under PC_GEN_BTB_EN.

## Test plan
- Reset and sequencing: rst=0 for 3 cycles, then 1 → ce=0, pc=0 on the first edge; ce=1 next; pc then reads 0, 4, 8, 0xC.
- Stall vs redirect:
  - stall[0]=1 for 2 cycles at pc=0x10 → pc holds 0x10.
  - redirect=1 with redirect_pc=0x203 while stalled → next pc=0x200.
- Allocate and predict: upd_valid, upd_pc=0x40, upd_target=0x100, taken → next visit to 0x40 gives pred_taken=1, pred_target=0x100, following pc=0x100.
- Counter hysteresis, on an entry at 0x40 in state WT:
  - One not-taken update → WNT; pred_taken=0, pc→0x44.
  - Two taken updates → ST.
  - One not-taken update → WT; still predicts taken.
- Aliasing and wrap:
  - BTB_ENTRIES=16, entry at 0x40 valid → lookup at 0x80 (same index, different tag) misses.
  - pc=0xFFFFFFFC with no prediction → next pc=0x0.
- Same-cycle lookup/update at the current pc → old prediction used that cycle, new one the following cycle. With PC_GEN_BTB_EN undefined, pred_taken stays 0 throughout.
